ps2_mouse_tracker: RTL and testbench
====================================

// Module: ps2_mouse_tracker
// PURPOSE
//  Producer side of the mouse interface: decodes a PS/2 mouse byte stream into
//  3-byte movement packets and drives mouse_x/mouse_y/mouse_pressed_.
//  Sits between the board PS/2 pins and counter-style consumers that sample
//  mouse_x and mouse_pressed_ on their own clock edges.
//  Position is accumulated and clamped so consumers only ever see absolute
//  coordinates.
// PARAMETERS
//  X_MAX           16'd639  upper clamp for mouse_x (lower clamp is 0)
//  Y_MAX           16'd479  upper clamp for mouse_y (lower clamp is 0)
//  X_INIT          16'd320  mouse_x value after reset
//  Y_INIT          16'd240  mouse_y value after reset
//  TIMEOUT_CYCLES  20000    clock cycles without a PS/2 falling edge before a partial frame/packet is dropped
// PORTS
//  clock          in   1   system clock; all state on posedge
//  reset_         in   1   asynchronous, active-high reset
//  ps2_clock      in   1   raw PS/2 clock pin, asynchronous
//  ps2_data       in   1   raw PS/2 data pin, asynchronous
//  mouse_x        out  16  absolute X position, 0..X_MAX
//  mouse_y        out  16  absolute Y position, 0..Y_MAX (up = increasing)
//  mouse_pressed_ out  1   1 while left button held (per last good packet)
//  packet_valid   out  1   one-cycle pulse when a packet is applied
//  frame_error    out  1   one-cycle pulse on parity/stop/timeout/sync error
// BEHAVIOUR
//  Reset values: mouse_x=X_INIT, mouse_y=Y_INIT, mouse_pressed_=0,
//   packet_valid=0, frame_error=0. Byte FSM=IDLE, packet index=0.
//  Input: ps2_clock and ps2_data each pass through a 2-FF synchroniser.
//   A falling edge is sync'd clock 1->0 between consecutive cycles. Data is
//   sampled on that edge only.
//  Byte FSM (one transition per falling edge):
//   - IDLE: data=0 (start) -> DATA, bit count=0. data=1 -> stay in IDLE, no error.
//   - DATA: shift in LSB first. After 8 bits -> PARITY.
//   - PARITY: capture the bit -> STOP.
//   - STOP: data=1 and odd parity over 8 data bits + parity bit -> byte done.
//     Otherwise frame_error pulse and packet index=0. Either way -> IDLE.
//  Timeout: a counter clears on every falling edge. In non-IDLE states, or
//   IDLE with packet index!=0, reaching TIMEOUT_CYCLES gives a frame_error
//   pulse, Byte FSM=IDLE and packet index=0.
//  Packet assembly: index 0 -> byte0 (status), 1 -> dx, 2 -> dy.
//   - byte0 with bit3=0 is a sync error: frame_error pulse, index stays 0.
//   - On byte 2 done: index=0.
//     - If byte0[6] (X ovf) or byte0[7] (Y ovf) is set: positions unchanged,
//       mouse_pressed_ still updates, packet_valid still pulses.
//     - Otherwise apply dx={byte0[4],dx} and dy={byte0[5],dy} as 9-bit
//       two's complement.
//  Arithmetic: new = pos + sext(delta) in signed 18 bits, then clamp:
//   <0 -> 0; >MAX -> MAX. No wrap-around.
//  Update timing: outputs update and packet_valid pulses in the cycle after the
//   falling edge that completes byte 2. mouse_pressed_=byte0[0] at that time.
//  A start bit arriving while packet_valid is pulsing is accepted normally;
//   no bytes are ever dropped due to output update.
//  reset_ mid-frame: immediate return to reset values; the partial frame is lost.
// STRUCTURE
//  ps2_mouse_pkg: byte FSM state enum (IDLE, DATA, PARITY, STOP),
//   packet byte-index constants, status-byte bit positions (BTN_L=0, SYNC=3,
//   XS=4, YS=5, XO=6, YO=7).
//  Sub-module ps2_byte_receiver: synchroniser, edge detect, byte FSM, timeout.
//   Outputs byte_data[7:0], byte_valid, byte_error.
//  Top level holds packet assembly, accumulation and clamping.
// TESTING
//  1 Reset, send status 8'h09, dx 8'h05, dy 8'h03 -> one packet_valid,
//    mouse_x=325, mouse_y=243, mouse_pressed_=1.
//  2 From reset, status 8'h18 (XS=1), dx 8'h00 (=-256) twice ->
//    mouse_x 64 then 0 (clamped), mouse_y unchanged 240.
//  3 Byte with bad parity -> frame_error pulse, no packet_valid; next valid
//    3-byte packet is applied normally.
//  4 Status byte 8'h00 (sync bit 0) -> frame_error, index stays 0;
//    following 8'h08,01,01 -> mouse_x=321, mouse_y=241.
//  5 Stop after 5 data bits, idle TIMEOUT_CYCLES -> frame_error, then a full
//    packet decodes correctly.
//  6 Status 8'h48 (X ovf) with dx 8'h7F, dy 8'h01 -> packet_valid,
//    mouse_x=320, mouse_y=240; assert reset_ mid-byte -> all outputs at reset values.

Source files
------------

// File: rtl/ps2_mouse_pkg.sv
// Shared types and constants for the PS/2 mouse tracker.
// Byte FSM states, packet indices, status-byte layout and clamp helper.
package ps2_mouse_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } byte_state_t;

  localparam logic [1:0] IDX_STAT = 2'd0;
  localparam logic [1:0] IDX_DX   = 2'd1;
  localparam logic [1:0] IDX_DY   = 2'd2;

  localparam int BTN_L = 0;
  localparam int SYNC  = 3;
  localparam int XS    = 4;
  localparam int YS    = 5;
  localparam int XO    = 6;
  localparam int YO    = 7;

  typedef struct packed {
    logic ovf;
    logic ys;
    logic xs;
    logic btn;
  } status_t;

  // pos + sext(d) in 18 signed bits, clamped to 0..maxv
  function automatic logic [15:0] clamp_add(
    input logic [15:0] pos,
    input logic [8:0]  d,
    input logic [15:0] maxv
  );
    logic signed [17:0] sum;
    sum = $signed({2'b00, pos})
        + $signed({{9{d[8]}}, d});
    if (sum < 18'sd0)
      return 16'd0;
    if (sum > $signed({2'b00, maxv}))
      return maxv;
    return sum[15:0];
  endfunction

endpackage

// File: rtl/ps2_byte_receiver.sv
// PS/2 byte receiver: sync, falling-edge detect, framing FSM, timeout.
// Ports: clock, reset_, ps2_clock, ps2_data, pkt_busy -> byte_data/valid/error.
module ps2_byte_receiver
  import ps2_mouse_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clock,
  input  logic       reset_,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  input  logic       pkt_busy,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST =
    TW'(TIMEOUT_CYCLES - 1);

  logic clk_s1, clk_s2, clk_q;
  logic dat_s1, dat_s2;

  byte_state_t state, state_d;
  logic [2:0]  bit_cnt, bit_cnt_d;
  logic [7:0]  shreg, shreg_d;
  logic        par_bit, par_bit_d;
  logic [TW-1:0] tmo_cnt;

  logic fall;
  logic active;
  logic timeout;

  assign fall    = clk_q & ~clk_s2;
  // A partial packet also counts as "in progress"
  assign active  = (state != IDLE) | pkt_busy;
  assign timeout = active & ~fall &
                   (tmo_cnt == TMO_LAST);

  assign byte_data = shreg;

  always_ff @(posedge clock or posedge reset_) begin
    if (reset_) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_q  <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clock;
      clk_s2 <= clk_s1;
      clk_q  <= clk_s2;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  always_ff @(posedge clock or posedge reset_) begin
    if (reset_) begin
      tmo_cnt <= '0;
    end else if (fall | ~active | timeout) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset_) begin
    if (reset_) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      state   <= state_d;
      bit_cnt <= bit_cnt_d;
      shreg   <= shreg_d;
      par_bit <= par_bit_d;
    end
  end

  always_comb begin
    state_d    = state;
    bit_cnt_d  = bit_cnt;
    shreg_d    = shreg;
    par_bit_d  = par_bit;
    byte_valid = 1'b0;
    byte_error = 1'b0;
    if (timeout) begin
      state_d    = IDLE;
      byte_error = 1'b1;
    end else if (fall) begin
      unique case (state)
        IDLE: begin
          if (!dat_s2) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end
        end
        DATA: begin
          shreg_d   = {dat_s2, shreg[7:1]};
          bit_cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7)
            state_d = PARITY;
        end
        PARITY: begin
          par_bit_d = dat_s2;
          state_d   = STOP;
        end
        STOP: begin
          // odd parity: XOR over data+parity is 1
          if (dat_s2 && (^{shreg, par_bit}))
            byte_valid = 1'b1;
          else
            byte_error = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse tracker: assembles 3-byte packets into clamped absolute X/Y.
// Ports: clock, reset_, ps2_clock/data in; mouse_x/y, pressed, pulses out.
module ps2_mouse_tracker
  import ps2_mouse_pkg::*;
#(
  parameter logic [15:0] X_MAX  = 16'd639,
  parameter logic [15:0] Y_MAX  = 16'd479,
  parameter logic [15:0] X_INIT = 16'd320,
  parameter logic [15:0] Y_INIT = 16'd240,
  parameter int TIMEOUT_CYCLES  = 20000
) (
  input  logic        clock,
  input  logic        reset_,
  input  logic        ps2_clock,
  input  logic        ps2_data,
  output logic [15:0] mouse_x,
  output logic [15:0] mouse_y,
  output logic        mouse_pressed_,
  output logic        packet_valid,
  output logic        frame_error
);

  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_error;

  logic [1:0] idx, idx_d;
  status_t    stat, stat_d;
  logic [7:0] dx_q, dx_d;
  logic [15:0] x_d, y_d;
  logic       btn_d;
  logic       pv_d;
  logic       fe_d;

  ps2_byte_receiver #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clock      (clock),
    .reset_     (reset_),
    .ps2_clock  (ps2_clock),
    .ps2_data   (ps2_data),
    .pkt_busy   (idx != IDX_STAT),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_error (byte_error)
  );

  always_comb begin
    idx_d  = idx;
    stat_d = stat;
    dx_d   = dx_q;
    x_d    = mouse_x;
    y_d    = mouse_y;
    btn_d  = mouse_pressed_;
    pv_d   = 1'b0;
    fe_d   = 1'b0;
    unique case (1'b1)
      byte_error: begin
        fe_d  = 1'b1;
        idx_d = IDX_STAT;
      end
      byte_valid: begin
        case (idx)
          IDX_STAT: begin
            if (!byte_data[SYNC]) begin
              fe_d = 1'b1;
            end else begin
              stat_d.btn = byte_data[BTN_L];
              stat_d.xs  = byte_data[XS];
              stat_d.ys  = byte_data[YS];
              stat_d.ovf = byte_data[XO] |
                           byte_data[YO];
              idx_d = IDX_DX;
            end
          end
          IDX_DX: begin
            dx_d  = byte_data;
            idx_d = IDX_DY;
          end
          IDX_DY: begin
            idx_d = IDX_STAT;
            pv_d  = 1'b1;
            btn_d = stat.btn;
            if (!stat.ovf) begin
              x_d = clamp_add(mouse_x,
                      {stat.xs, dx_q}, X_MAX);
              y_d = clamp_add(mouse_y,
                      {stat.ys, byte_data}, Y_MAX);
            end
          end
          default: idx_d = IDX_STAT;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset_) begin
    if (reset_) begin
      idx            <= IDX_STAT;
      stat           <= '0;
      dx_q           <= '0;
      mouse_x        <= X_INIT;
      mouse_y        <= Y_INIT;
      mouse_pressed_ <= 1'b0;
      packet_valid   <= 1'b0;
      frame_error    <= 1'b0;
    end else begin
      idx            <= idx_d;
      stat           <= stat_d;
      dx_q           <= dx_d;
      mouse_x        <= x_d;
      mouse_y        <= y_d;
      mouse_pressed_ <= btn_d;
      packet_valid   <= pv_d;
      frame_error    <= fe_d;
    end
  end

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Bench for ps2_mouse_tracker: directed and random PS/2 packets
// against an integer position model with clamping.
module tb_ps2_mouse_tracker;

  localparam int TMO   = 600;
  localparam int X_MAX = 639;
  localparam int Y_MAX = 479;

  logic        clock;
  logic        reset_;
  logic        ps2_clock;
  logic        ps2_data;
  logic [15:0] mouse_x;
  logic [15:0] mouse_y;
  logic        mouse_pressed_;
  logic        packet_valid;
  logic        frame_error;

  int checks   = 0;
  int failures = 0;
  int pv_cnt   = 0;
  int fe_cnt   = 0;
  int pv0, fe0;
  int mx, my, mb;
  logic [7:0] st, rdx, rdy;

  ps2_mouse_tracker #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock          (clock),
    .reset_         (reset_),
    .ps2_clock      (ps2_clock),
    .ps2_data       (ps2_data),
    .mouse_x        (mouse_x),
    .mouse_y        (mouse_y),
    .mouse_pressed_ (mouse_pressed_),
    .packet_valid   (packet_valid),
    .frame_error    (frame_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // cycles spent high == number of single-cycle pulses
  always @(posedge clock) begin
    if (packet_valid) pv_cnt <= pv_cnt + 1;
    if (frame_error)  fe_cnt <= fe_cnt + 1;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v,
                                input int mx_);
    if (v < 0) return 0;
    if (v > mx_) return mx_;
    return v;
  endfunction

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (4) @(negedge clock);
    ps2_clock = 1'b0;
    repeat (8) @(negedge clock);
    ps2_clock = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input logic bad_par,
                            input logic bad_stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(~bad_stop);
    ps2_data = 1'b1;
    repeat (10) @(negedge clock);
  endtask

  task automatic do_reset();
    reset_ = 1'b1;
    repeat (3) @(negedge clock);
    reset_ = 1'b0;
    repeat (2) @(negedge clock);
    mx = 320;
    my = 240;
    mb = 0;
  endtask

  task automatic send_packet(input string tag,
                             input logic [7:0] s,
                             input logic [7:0] dx,
                             input logic [7:0] dy);
    int dxv, dyv;
    pv0 = pv_cnt;
    fe0 = fe_cnt;
    send_frame(s, 1'b0, 1'b0);
    send_frame(dx, 1'b0, 1'b0);
    send_frame(dy, 1'b0, 1'b0);
    if (!(s[6] || s[7])) begin
      dxv = int'(dx) - (s[4] ? 256 : 0);
      dyv = int'(dy) - (s[5] ? 256 : 0);
      mx = clampi(mx + dxv, X_MAX);
      my = clampi(my + dyv, Y_MAX);
    end
    mb = int'(s[0]);
    check({tag, "_pv"}, pv_cnt - pv0, 1);
    check({tag, "_fe"}, fe_cnt - fe0, 0);
    check({tag, "_x"}, mouse_x, mx);
    check({tag, "_y"}, mouse_y, my);
    check({tag, "_btn"}, mouse_pressed_, mb);
  endtask

  initial begin
    reset_    = 1'b1;
    ps2_clock = 1'b1;
    ps2_data  = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_x", mouse_x, 320);
    check("rst_y", mouse_y, 240);
    check("rst_btn", mouse_pressed_, 0);
    check("rst_pv", packet_valid, 0);
    check("rst_fe", frame_error, 0);
    reset_ = 1'b0;
    repeat (2) @(negedge clock);
    mx = 320; my = 240; mb = 0;

    // basic packet
    send_packet("t1", 8'h09, 8'h05, 8'h03);
    check("t1_xc", mouse_x, 325);
    check("t1_yc", mouse_y, 243);

    // negative X to lower clamp
    do_reset();
    send_packet("t2a", 8'h18, 8'h00, 8'h00);
    check("t2a_xc", mouse_x, 64);
    send_packet("t2b", 8'h18, 8'h00, 8'h00);
    check("t2b_xc", mouse_x, 0);

    // upper clamps on both axes
    send_packet("tmax1", 8'h08, 8'hFF, 8'hFF);
    send_packet("tmax2", 8'h08, 8'hFF, 8'hFF);
    send_packet("tmax3", 8'h08, 8'hFF, 8'hFF);
    check("tmax_xc", mouse_x, 639);
    check("tmax_yc", mouse_y, 479);

    // bad parity, then bad stop, each followed by good packet
    pv0 = pv_cnt; fe0 = fe_cnt;
    send_frame(8'h09, 1'b1, 1'b0);
    check("t3_par_fe", fe_cnt - fe0, 1);
    check("t3_par_pv", pv_cnt - pv0, 0);
    send_packet("t3a", 8'h29, 8'hF0, 8'hF0);
    pv0 = pv_cnt; fe0 = fe_cnt;
    send_frame(8'h08, 1'b0, 1'b0);
    send_frame(8'h11, 1'b0, 1'b1);
    check("t3_stop_fe", fe_cnt - fe0, 1);
    check("t3_stop_pv", pv_cnt - pv0, 0);
    send_packet("t3b", 8'h08, 8'h02, 8'h02);

    // sync error on status byte
    do_reset();
    pv0 = pv_cnt; fe0 = fe_cnt;
    send_frame(8'h00, 1'b0, 1'b0);
    check("t4_fe", fe_cnt - fe0, 1);
    check("t4_pv", pv_cnt - pv0, 0);
    send_packet("t4", 8'h08, 8'h01, 8'h01);
    check("t4_xc", mouse_x, 321);
    check("t4_yc", mouse_y, 241);

    // timeout on partial frame
    pv0 = pv_cnt; fe0 = fe_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'b1);
    repeat (TMO - 150) @(negedge clock);
    check("t5_early", fe_cnt - fe0, 0);
    repeat (300) @(negedge clock);
    check("t5_fe", fe_cnt - fe0, 1);
    check("t5_pv", pv_cnt - pv0, 0);
    send_packet("t5", 8'h08, 8'h04, 8'hFC);

    // timeout on partial packet between bytes
    fe0 = fe_cnt;
    send_frame(8'h08, 1'b0, 1'b0);
    repeat (TMO + 100) @(negedge clock);
    check("t5b_fe", fe_cnt - fe0, 1);
    send_packet("t5b", 8'h09, 8'h07, 8'h07);

    // overflow packet, then reset mid-byte
    do_reset();
    send_packet("t6", 8'h48, 8'h7F, 8'h01);
    check("t6_xc", mouse_x, 320);
    check("t6_yc", mouse_y, 240);
    send_packet("t6b", 8'h09, 8'h10, 8'h10);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    reset_ = 1'b1;
    repeat (2) @(negedge clock);
    check("t6_rst_x", mouse_x, 320);
    check("t6_rst_y", mouse_y, 240);
    check("t6_rst_btn", mouse_pressed_, 0);
    reset_ = 1'b0;
    ps2_data = 1'b1;
    repeat (4) @(negedge clock);
    mx = 320; my = 240; mb = 0;
    send_packet("t6c", 8'h38, 8'hFE, 8'hFD);

    // random packets
    for (int n = 0; n < 12; n++) begin
      st  = 8'($urandom);
      rdx = 8'($urandom);
      rdy = 8'($urandom);
      st[3] = 1'b1;
      if ($urandom_range(0, 4) != 0) st[7:6] = 2'b00;
      send_packet($sformatf("rnd%0d", n), st, rdx, rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
